// File: rtl/sobel_window_builder_pkg.sv
// -----------------------------------------------------------------------------
// sobel_window_builder_pkg
// Shared constants for the Sobel window builder: matrix_size codes, element
// and packed-matrix widths, FSM state codes and the (row, col) byte-offset
// helper used to place window elements into the 200-bit matrix_a word.
// -----------------------------------------------------------------------------
package sobel_window_builder_pkg;

  // matrix_size encodings (window dimension K = code + 2)
  localparam logic [1:0] MSIZE_2X2 = 2'b00;
  localparam logic [1:0] MSIZE_3X3 = 2'b01;
  localparam logic [1:0] MSIZE_4X4 = 2'b10;
  localparam logic [1:0] MSIZE_5X5 = 2'b11;

  localparam int ELEM_W = 8;
  localparam int MAX_K  = 5;
  localparam int MAT_W  = MAX_K * MAX_K * ELEM_W;

  // FSM state codes
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_FLUSH = 2'd2;

  // Bit offset of element (r, c) inside the packed matrix
  function automatic int byte_off(input int r, input int c);
    return (MAX_K * ELEM_W * r) + (ELEM_W * c);
  endfunction

endpackage

// File: rtl/sobel_window_builder_if.sv
// -----------------------------------------------------------------------------
// sobel_window_builder_if
// Pixel-in / window-out handshake bundle.
//   pix_data/pix_valid/pix_ready : raster pixel stream into the builder
//   win_valid/win_ready          : window handshake towards the coprocessor
//   matrix_a/win_x/win_y         : packed window and its top-left coordinate
// Modports: slave = window builder, master = pixel source / window consumer.
// -----------------------------------------------------------------------------
interface sobel_window_builder_if
  import sobel_window_builder_pkg::*;
#(
  parameter int DIM_W = 10
);
  logic [ELEM_W-1:0] pix_data;
  logic              pix_valid;
  logic              pix_ready;
  logic              win_valid;
  logic              win_ready;
  logic [MAT_W-1:0]  matrix_a;
  logic [DIM_W-1:0]  win_x;
  logic [DIM_W-1:0]  win_y;

  modport slave (
    input  pix_data, pix_valid, win_ready,
    output pix_ready, win_valid, matrix_a, win_x, win_y
  );

  modport master (
    output pix_data, pix_valid, win_ready,
    input  pix_ready, win_valid, matrix_a, win_x, win_y
  );
endinterface

// File: rtl/sobel_window_builder_line.sv
// -----------------------------------------------------------------------------
// sobel_line_buffer
// Four line buffers sharing one column address. A write at column addr_i
// pushes wdata_i into line 0 and moves each older line's byte at that column
// down one line. rdata_o returns the (pre-write) bytes of all four lines at
// addr_i combinationally: rdata_o[0] is the previous row, rdata_o[3] the row
// four above.
// Ports: clk, addr_i (column), wr_i (write strobe), wdata_i (pixel),
//        rdata_o (4 bytes for the addressed column).
// -----------------------------------------------------------------------------
module sobel_line_buffer
  import sobel_window_builder_pkg::*;
#(
  parameter int MAX_WIDTH = 640,
  parameter int DIM_W     = 10
) (
  input  logic                   clk,
  input  logic [DIM_W-1:0]       addr_i,
  input  logic                   wr_i,
  input  logic [ELEM_W-1:0]      wdata_i,
  output logic [3:0][ELEM_W-1:0] rdata_o
);

  logic [ELEM_W-1:0] mem_q [4][MAX_WIDTH];

  // Column write with line shift; storage is not reset, every column is
  // rewritten before a window can depend on it.
  always_ff @(posedge clk) begin
    if (wr_i) begin
      mem_q[0][addr_i] <= wdata_i;
      for (int i = 1; i < 4; i++) begin
        mem_q[i][addr_i] <= mem_q[i-1][addr_i];
      end
    end
  end

  // Combinational read of the addressed column
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      rdata_o[i] = mem_q[i][addr_i];
    end
  end

endmodule

// File: rtl/sobel_window_builder.sv
// -----------------------------------------------------------------------------
// sobel_window_builder
// Turns a raster pixel stream into sliding KxK windows (K = matrix_size + 2)
// packed as matrix_a, element (r,c) at bits [40r+8c +: 8]. Only windows fully
// inside the image are emitted, one cycle after the accept of their
// bottom-right pixel.
// Ports: clk, rst_n (async active-low), start/img_width/img_height/
//        matrix_size (frame configuration), bus (pixel and window handshakes,
//        see sobel_window_builder_if), busy, frame_done, cfg_err.
// Optional: define WINDOW_STALL_CNT_EN to add the 32-bit stall_cnt output
//        counting cycles where a window waits for the consumer.
// -----------------------------------------------------------------------------
module sobel_window_builder
  import sobel_window_builder_pkg::*;
#(
  parameter int MAX_WIDTH  = 640,
  parameter int MAX_HEIGHT = 480,
  parameter int DIM_W      = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [DIM_W-1:0]      img_width,
  input  logic [DIM_W-1:0]      img_height,
  input  logic [1:0]            matrix_size,
  sobel_window_builder_if.slave bus,
  output logic                  busy,
  output logic                  frame_done,
  output logic                  cfg_err
`ifdef WINDOW_STALL_CNT_EN
  ,
  output logic [31:0]           stall_cnt
`endif
);

  logic [1:0]        state_q, state_d;
  logic [DIM_W-1:0]  col_q, col_d, row_q, row_d;
  logic [DIM_W-1:0]  w_q, w_d, h_q, h_d;
  logic [1:0]        ksz_q, ksz_d;
  logic [ELEM_W-1:0] win_q [MAX_K][MAX_K];
  logic [ELEM_W-1:0] win_d [MAX_K][MAX_K];
  logic              win_valid_q, win_valid_d;
  logic [MAT_W-1:0]  mat_q, mat_d;
  logic [DIM_W-1:0]  win_x_q, win_x_d, win_y_q, win_y_d;
  logic              busy_q, busy_d, frame_done_q, frame_done_d;
  logic              cfg_err_q, cfg_err_d;

  logic                   pix_ready_s, accept_s, emit_s, cfg_ok_s, last_s;
  logic [DIM_W-1:0]       km1_s;
  logic [2:0]             off_s;
  logic [3:0][ELEM_W-1:0] rd_s;
  logic [MAT_W-1:0]       mat_next_s;

  sobel_line_buffer #(.MAX_WIDTH(MAX_WIDTH), .DIM_W(DIM_W)) u_lines (
    .clk     (clk),
    .addr_i  (col_q),
    .wr_i    (accept_s),
    .wdata_i (bus.pix_data),
    .rdata_o (rd_s)
  );

  // Handshake qualifiers and frame-geometry helpers
  always_comb begin
    pix_ready_s = (state_q == ST_RUN) && (!win_valid_q || bus.win_ready);
    accept_s    = pix_ready_s && bus.pix_valid;
    km1_s       = DIM_W'(ksz_q) + DIM_W'(1);
    emit_s      = accept_s && (col_q >= km1_s) && (row_q >= km1_s);
    last_s      = (col_q == w_q - DIM_W'(1)) && (row_q == h_q - DIM_W'(1));
    cfg_ok_s    = (img_width != '0) && (img_width <= DIM_W'(MAX_WIDTH)) &&
                  (img_height != '0) && (img_height <= DIM_W'(MAX_HEIGHT));
  end

  // First used row/column of the 5x5 register window (window is right/bottom aligned)
  always_comb begin
    case (ksz_q)
      MSIZE_2X2: off_s = 3'd3;
      MSIZE_3X3: off_s = 3'd2;
      MSIZE_4X4: off_s = 3'd1;
      MSIZE_5X5: off_s = 3'd0;
      default:   off_s = 3'd0;
    endcase
  end

  // Register-window shift: column 4 receives line-buffer bytes plus the new pixel
  always_comb begin
    for (int r = 0; r < MAX_K; r++) begin
      for (int c = 0; c < MAX_K - 1; c++) begin
        win_d[r][c] = accept_s ? win_q[r][c+1] : win_q[r][c];
      end
    end
    for (int r = 0; r < MAX_K - 1; r++) begin
      win_d[r][MAX_K-1] = accept_s ? rd_s[3-r] : win_q[r][MAX_K-1];
    end
    win_d[MAX_K-1][MAX_K-1] = accept_s ? bus.pix_data : win_q[MAX_K-1][MAX_K-1];
  end

  // Pack the lower-right KxK corner of the shifted window into matrix format
  always_comb begin
    mat_next_s = '0;
    for (int r = 0; r < MAX_K; r++) begin
      for (int c = 0; c < MAX_K; c++) begin
        if ((3'(r) < 3'd5 - off_s) && (3'(c) < 3'd5 - off_s)) begin
          mat_next_s[byte_off(r, c) +: ELEM_W] = win_d[off_s + 3'(r)][off_s + 3'(c)];
        end else begin
          mat_next_s[byte_off(r, c) +: ELEM_W] = '0;
        end
      end
    end
  end

  // FSM, coordinate counters and output register next state
  always_comb begin
    state_d      = state_q;
    col_d        = col_q;
    row_d        = row_q;
    w_d          = w_q;
    h_d          = h_q;
    ksz_d        = ksz_q;
    cfg_err_d    = 1'b0;
    frame_done_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start && cfg_ok_s) begin
          w_d     = img_width;
          h_d     = img_height;
          ksz_d   = matrix_size;
          col_d   = '0;
          row_d   = '0;
          state_d = ST_RUN;
        end else if (start) begin
          cfg_err_d = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (accept_s && last_s) begin
          state_d = ST_FLUSH;
        end else if (accept_s && (col_q == w_q - DIM_W'(1))) begin
          col_d = '0;
          row_d = row_q + DIM_W'(1);
        end else if (accept_s) begin
          col_d = col_q + DIM_W'(1);
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_FLUSH: begin
        if (!win_valid_q || bus.win_ready) begin
          frame_done_d = 1'b1;
          state_d      = ST_IDLE;
        end else begin
          state_d = ST_FLUSH;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A new window may replace a consumed one in the same cycle
    win_valid_d = win_valid_q;
    mat_d       = mat_q;
    win_x_d     = win_x_q;
    win_y_d     = win_y_q;
    if (emit_s) begin
      win_valid_d = 1'b1;
      mat_d       = mat_next_s;
      win_x_d     = col_q - km1_s;
      win_y_d     = row_q - km1_s;
    end else if (win_valid_q && bus.win_ready) begin
      win_valid_d = 1'b0;
    end else begin
      win_valid_d = win_valid_q;
    end
    busy_d = (state_d == ST_RUN) || (state_d == ST_FLUSH);
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      col_q        <= '0;
      row_q        <= '0;
      w_q          <= '0;
      h_q          <= '0;
      ksz_q        <= 2'b00;
      for (int r = 0; r < MAX_K; r++) begin
        for (int c = 0; c < MAX_K; c++) begin
          win_q[r][c] <= '0;
        end
      end
      win_valid_q  <= 1'b0;
      mat_q        <= '0;
      win_x_q      <= '0;
      win_y_q      <= '0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      cfg_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      col_q        <= col_d;
      row_q        <= row_d;
      w_q          <= w_d;
      h_q          <= h_d;
      ksz_q        <= ksz_d;
      win_q        <= win_d;
      win_valid_q  <= win_valid_d;
      mat_q        <= mat_d;
      win_x_q      <= win_x_d;
      win_y_q      <= win_y_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
      cfg_err_q    <= cfg_err_d;
    end
  end

`ifdef WINDOW_STALL_CNT_EN
  logic [31:0] stall_cnt_q;

  // Saturating count of cycles a window waits on the consumer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= 32'd0;
    end else if ((state_q == ST_IDLE) && start && cfg_ok_s) begin
      stall_cnt_q <= 32'd0;
    end else if (win_valid_q && !bus.win_ready && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end else begin
      stall_cnt_q <= stall_cnt_q;
    end
  end

  assign stall_cnt = stall_cnt_q;
`endif

  assign bus.pix_ready = pix_ready_s;
  assign bus.win_valid = win_valid_q;
  assign bus.matrix_a  = mat_q;
  assign bus.win_x     = win_x_q;
  assign bus.win_y     = win_y_q;
  assign busy          = busy_q;
  assign frame_done    = frame_done_q;
  assign cfg_err       = cfg_err_q;

endmodule

// File: tb/tb_sobel_window_builder.sv
// -----------------------------------------------------------------------------
// tb_sobel_window_builder
// Scoreboard bench: each frame's expected windows are computed from the image
// array and queued at stimulus time; a monitor pops and compares every window
// handed to the consumer.
// -----------------------------------------------------------------------------
module tb_sobel_window_builder;
  import sobel_window_builder_pkg::*;

  localparam int DIM_W = 10;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start;
  logic [DIM_W-1:0] img_width, img_height;
  logic [1:0]       matrix_size;
  logic             busy, frame_done, cfg_err;
`ifdef WINDOW_STALL_CNT_EN
  logic [31:0]      stall_cnt;
`endif

  sobel_window_builder_if #(.DIM_W(DIM_W)) bus ();

  sobel_window_builder #(.MAX_WIDTH(640), .MAX_HEIGHT(480), .DIM_W(DIM_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .img_width   (img_width),
    .img_height  (img_height),
    .matrix_size (matrix_size),
    .bus         (bus),
    .busy        (busy),
    .frame_done  (frame_done),
    .cfg_err     (cfg_err)
`ifdef WINDOW_STALL_CNT_EN
    ,
    .stall_cnt   (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  logic [MAT_W-1:0] exp_mat_q [$];
  int               exp_x_q [$];
  int               exp_y_q [$];
  logic [7:0]       img [256];

  int ready_mode = 0;
  bit valid_rand = 1'b0;
  bit stall_done = 1'b0;
  int cfg_err_cnt = 0;

  task automatic check(input string name, input logic [MAT_W-1:0] act, input logic [MAT_W-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Reference: every fully-inside KxK window in raster order of its top-left corner
  task automatic push_expected(input int k, input int w, input int h);
    logic [MAT_W-1:0] m;
    for (int y = 0; y + k <= h; y++) begin
      for (int x = 0; x + k <= w; x++) begin
        m = '0;
        for (int r = 0; r < k; r++)
          for (int c = 0; c < k; c++)
            m[40*r + 8*c +: 8] = img[(y + r) * w + x + c];
        exp_mat_q.push_back(m);
        exp_x_q.push_back(x);
        exp_y_q.push_back(y);
      end
    end
  endtask

  // Monitor / scoreboard
  logic [MAT_W-1:0] mon_m;
  int               mon_x, mon_y;
  always @(negedge clk) begin
    if (rst_n && bus.win_valid && bus.win_ready) begin
      if (exp_mat_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_window: got x=%0d y=%0d expected none", bus.win_x, bus.win_y);
      end else begin
        mon_m = exp_mat_q.pop_front();
        mon_x = exp_x_q.pop_front();
        mon_y = exp_y_q.pop_front();
        check("window_matrix", bus.matrix_a, mon_m);
        check("win_x", MAT_W'(bus.win_x), MAT_W'(mon_x));
        check("win_y", MAT_W'(bus.win_y), MAT_W'(mon_y));
      end
    end
    if (cfg_err) cfg_err_cnt++;
  end

  // Consumer: always ready, random, or one 7-cycle stall on the first window
  logic [MAT_W-1:0] held_m;
  initial begin
    bus.win_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (ready_mode)
        0: bus.win_ready = 1'b1;
        1: bus.win_ready = 1'($urandom_range(0, 1));
        2: begin
          if (bus.win_valid && !stall_done) begin
            bus.win_ready = 1'b0;
            held_m = bus.matrix_a;
            for (int i = 0; i < 7; i++) begin
              @(negedge clk);
              check("stall_matrix_stable", bus.matrix_a, held_m);
              check("stall_pix_ready", MAT_W'(bus.pix_ready), '0);
              @(posedge clk); #1;
            end
            bus.win_ready = 1'b1;
            stall_done = 1'b1;
          end else begin
            bus.win_ready = 1'b1;
          end
        end
        default: bus.win_ready = 1'b1;
      endcase
    end
  end

  task automatic do_start(input int code, input int w, input int h);
    matrix_size = 2'(code);
    img_width   = DIM_W'(w);
    img_height  = DIM_W'(h);
    start       = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic feed(input int n, output int got);
    int  guard = 0;
    bit  acc;
    got = 0;
    while (got < n && guard < 5000) begin
      bus.pix_valid = valid_rand ? 1'($urandom_range(0, 1)) : 1'b1;
      bus.pix_data  = img[got];
      @(negedge clk);
      acc = bus.pix_valid && bus.pix_ready;
      @(posedge clk); #1;
      if (acc) got++;
      guard++;
    end
    bus.pix_valid = 1'b0;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (n < 200) begin
      @(negedge clk);
      if (frame_done) break;
      n++;
    end
    @(posedge clk); #1;
  endtask

  task automatic fill_image(input int n, input bit seq);
    for (int i = 0; i < n; i++) img[i] = seq ? 8'(i + 1) : 8'($urandom_range(0, 255));
  endtask

  task automatic run_frame(input int code, input int w, input int h, input bit degen);
    int got, n;
    push_expected(code + 2, w, h);
    do_start(code, w, h);
    @(negedge clk);
    check("busy_after_start", MAT_W'(busy), MAT_W'(1));
    @(posedge clk); #1;
    feed(w * h, got);
    check("pixels_consumed", MAT_W'(got), MAT_W'(w * h));
    wait_done(n);
    if (n >= 200) check("frame_done_timeout", MAT_W'(n), MAT_W'(0));
    if (degen) check("flush_to_frame_done", MAT_W'(n), MAT_W'(1));
    check("all_windows_out", MAT_W'(exp_mat_q.size()), '0);
    check("idle_not_busy", MAT_W'(busy), '0);
  endtask

  initial begin
    int got;
    start = 1'b0; img_width = '0; img_height = '0; matrix_size = 2'b00;
    bus.pix_valid = 1'b0; bus.pix_data = 8'd0;
    repeat (2) @(negedge clk);
    check("rst_pix_ready", MAT_W'(bus.pix_ready), '0);
    check("rst_win_valid", MAT_W'(bus.win_valid), '0);
    check("rst_busy", MAT_W'(busy), '0);
    check("rst_frame_done", MAT_W'(frame_done), '0);
    check("rst_cfg_err", MAT_W'(cfg_err), '0);
    check("rst_matrix_a", bus.matrix_a, '0);
    check("rst_win_xy", MAT_W'({bus.win_x, bus.win_y}), '0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // K=3 4x3, sequential pixels
    fill_image(12, 1'b1);
    run_frame(1, 4, 3, 1'b0);

    // K=5 5x5, one window
    fill_image(25, 1'b1);
    run_frame(3, 5, 5, 1'b0);

    // K=3 4x3 with a 7-cycle consumer stall on the first window
    fill_image(12, 1'b1);
    stall_done = 1'b0;
    ready_mode = 2;
    run_frame(1, 4, 3, 1'b0);
    check("stall_happened", MAT_W'(stall_done), MAT_W'(1));
    ready_mode = 0;

    // Degenerate K=5 on 3x2
    fill_image(6, 1'b1);
    run_frame(3, 3, 2, 1'b1);

    // Rejected configurations
    do_start(1, 0, 3);
    @(negedge clk);
    check("cfg_err_width0", MAT_W'(cfg_err), MAT_W'(1));
    check("busy_after_bad_cfg0", MAT_W'(busy), '0);
    @(posedge clk); #1;
    do_start(1, 641, 3);
    @(negedge clk);
    check("cfg_err_width_max_plus1", MAT_W'(cfg_err), MAT_W'(1));
    check("busy_after_bad_cfg1", MAT_W'(busy), '0);
    @(posedge clk); #1;
    repeat (2) @(posedge clk); #1;
    check("cfg_err_pulse_count", MAT_W'(cfg_err_cnt), MAT_W'(2));

    // Reset in the middle of a frame, then the same frame again
    fill_image(12, 1'b1);
    do_start(1, 4, 3);
    feed(5, got);
    rst_n = 1'b0;
    @(negedge clk);
    check("midreset_busy", MAT_W'(busy), '0);
    check("midreset_win_valid", MAT_W'(bus.win_valid), '0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_frame(1, 4, 3, 1'b0);

    // Randomized frames with random source and consumer pacing
    ready_mode = 1;
    valid_rand = 1'b1;
    for (int f = 0; f < 16; f++) begin
      int code, w, h;
      code = $urandom_range(0, 3);
      w    = $urandom_range(1, 12);
      h    = $urandom_range(1, 12);
      fill_image(w * h, 1'b0);
      run_frame(code, w, h, 1'b0);
    end
    ready_mode = 0;
    valid_rand = 1'b0;

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
